// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory_game_n pair-memory controller.
//   state_e       : controller FSM states
//   onehot_bit    : one bit of the onehot mask of an LED index (out-of-range -> 0)
//   idx_field_lsb : bit offset of index a_k / b_k inside the packed pair bus
package memory_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_PAIRS,
    S_FLASH,
    S_GAP,
    S_ENTER,
    S_END
  } state_e;

  // Mask bit 'led' of onehot(idx); indices at or beyond n_leds light nothing.
  function automatic logic onehot_bit(input int unsigned idx, input int unsigned led,
                                      input int unsigned n_leds);
    return (idx < n_leds) && (idx == led);
  endfunction

  // Pair k is packed as {a_k, b_k} with pair 0 in the LSBs.
  function automatic int unsigned idx_field_lsb(input int unsigned pair, input logic is_a,
                                                input int unsigned idx_w);
    return (2 * pair + (is_a ? 1 : 0)) * idx_w;
  endfunction

endpackage

// File: rtl/memory_game_n_if.sv
// Request/response bus between the game controller and the pair generator.
//   pair_req   : one-cycle request from the controller
//   pair_valid : pair_idx holds a fresh set of pairs
//   pair_idx   : NUM_PAIRS packed {a_k, b_k} index pairs, pair 0 in the LSBs
// master = controller side, slave = pair generator side.
interface memory_game_n_if #(
  parameter int unsigned NUM_PAIRS = 3,
  parameter int unsigned IDX_W     = 4
);
  logic                          pair_req;
  logic                          pair_valid;
  logic [2*NUM_PAIRS*IDX_W-1:0]  pair_idx;

  modport master (output pair_req, input pair_valid, input pair_idx);
  modport slave  (input pair_req, output pair_valid, output pair_idx);
endinterface

// File: rtl/memory_game_n_timer.sv
// game_phase_timer: loadable down-counter shared by the FLASH and GAP phases.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : count qualifier (counter freezes when low)
//   load      : load load_val (wins over counting)
//   load_val  : phase length in enabled cycles (>= 1)
//   expire    : one-cycle pulse on the last enabled cycle of the phase
module game_phase_timer #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                          cnt_d = load_val;
    else if (enable && cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = enable && (cnt_q == CNT_W'(1));
endmodule

// File: rtl/memory_game_n.sv
// memory_game_n: pair-memory game controller.
// Requests index pairs, flashes a growing sequence of pair masks on red_light,
// then checks switch_in against each mask on b_in presses.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : FSM/timer advance qualifier
//   b_in         : debounced button pulse
//   switch_in    : player entry
//   game_timeout : global time-up (ignored in IDLE)
//   pair_bus     : pair generator handshake (memory_game_n_if.master)
//   red_light    : flashed mask, green : per-pair matched flags
//   score, level, lives, end_game : game status (all registered)
// Optional feature macro: MEMORY_GAME_LIVES_EN -- mismatches cost a life and
// replay the round; without it a mismatch restarts at level 1 with new pairs.
module memory_game_n
  import memory_game_pkg::*;
#(
  parameter int unsigned N_LEDS       = 16,
  parameter int unsigned NUM_PAIRS    = 3,
  parameter int unsigned IDX_W        = $clog2(N_LEDS),
  parameter int unsigned FLASH_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned LIVES        = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                b_in,
  input  logic [N_LEDS-1:0]                   switch_in,
  input  logic                                game_timeout,
  memory_game_n_if.master                     pair_bus,
  output logic [N_LEDS-1:0]                   red_light,
  output logic [NUM_PAIRS-1:0]                green,
  output logic [SCORE_W-1:0]                  score,
  output logic [$clog2(NUM_PAIRS+1)-1:0]      level,
  output logic [$clog2(LIVES+1)-1:0]          lives,
  output logic                                end_game
);
  localparam int unsigned LVL_W = $clog2(NUM_PAIRS + 1);
  localparam int unsigned LV_W  = $clog2(LIVES + 1);
  localparam int unsigned TMAX  = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W = $clog2(TMAX + 1);
`ifdef MEMORY_GAME_LIVES_EN
  localparam logic [LV_W-1:0] LIVES_INIT = LV_W'(LIVES);
`else
  localparam logic [LV_W-1:0] LIVES_INIT = '0;
`endif

  state_e                             state_q, state_d;
  logic [LVL_W-1:0]                   k_q, k_d;
  logic [NUM_PAIRS-1:0][N_LEDS-1:0]   mask_q, mask_d, new_mask;
  logic [N_LEDS-1:0]                  red_q, red_d;
  logic [NUM_PAIRS-1:0]               green_q, green_d;
  logic [SCORE_W-1:0]                 score_q, score_d;
  logic [LVL_W-1:0]                   level_q, level_d;
  logic [LV_W-1:0]                    lives_q, lives_d;
  logic                               end_game_q, end_game_d;
  logic                               pair_req_q, pair_req_d;

  logic                               tmr_load, tmr_expire;
  logic [CNT_W-1:0]                   tmr_val;
  logic                               last_pair;

  game_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Masks for the pairs in play this round; pairs beyond level stay dark.
  always_comb begin
    int unsigned a_idx, b_idx;
    new_mask = '0;
    a_idx    = 0;
    b_idx    = 0;
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      a_idx = 32'(pair_bus.pair_idx[idx_field_lsb(p, 1'b1, IDX_W) +: IDX_W]);
      b_idx = 32'(pair_bus.pair_idx[idx_field_lsb(p, 1'b0, IDX_W) +: IDX_W]);
      if (p < 32'(level_q)) begin
        for (int unsigned j = 0; j < N_LEDS; j++)
          new_mask[p][j] = onehot_bit(a_idx, j, N_LEDS) | onehot_bit(b_idx, j, N_LEDS);
      end
    end
  end

  assign last_pair = (k_q == level_q - LVL_W'(1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mask_d     = mask_q;
    red_d      = red_q;
    green_d    = green_q;
    score_d    = score_q;
    level_d    = level_q;
    lives_d    = lives_q;
    end_game_d = end_game_q;
    pair_req_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (enable && game_timeout && state_q != S_IDLE) begin
      state_d    = S_END;
      red_d      = '0;
      green_d    = '0;
      end_game_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (enable && b_in) begin
          score_d    = '0;
          level_d    = LVL_W'(1);
          lives_d    = LIVES_INIT;
          end_game_d = 1'b0;
          green_d    = '0;
          red_d      = '0;
          state_d    = S_REQ;
        end
        S_REQ: if (enable) begin
          pair_req_d = 1'b1;
          green_d    = '0;
          state_d    = S_WAIT_PAIRS;
        end
        S_WAIT_PAIRS: if (pair_bus.pair_valid) begin
          mask_d   = new_mask;
          k_d      = '0;
          red_d    = new_mask[0];
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(FLASH_CYCLES);
          state_d  = S_FLASH;
        end
        S_FLASH: if (tmr_expire) begin
          red_d = '0;
          if (last_pair) begin
            k_d     = '0;
            state_d = S_ENTER;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(GAP_CYCLES);
            state_d  = S_GAP;
          end
        end
        S_GAP: if (tmr_expire) begin
          k_d      = k_q + LVL_W'(1);
          red_d    = mask_q[k_q + LVL_W'(1)];
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(FLASH_CYCLES);
          state_d  = S_FLASH;
        end
        S_ENTER: if (enable && b_in) begin
          if (switch_in == mask_q[k_q]) begin
            green_d[k_q] = 1'b1;
            if (last_pair) begin
              score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
              level_d = (level_q >= LVL_W'(NUM_PAIRS)) ? level_q : level_q + LVL_W'(1);
              state_d = S_REQ;
            end else begin
              k_d = k_q + LVL_W'(1);
            end
          end else begin
            green_d = '0;
`ifdef MEMORY_GAME_LIVES_EN
            if (lives_q <= LV_W'(1)) begin
              lives_d    = '0;
              red_d      = '0;
              end_game_d = 1'b1;
              state_d    = S_END;
            end else begin
              // Replay the latched masks without asking for new pairs.
              lives_d  = lives_q - LV_W'(1);
              k_d      = '0;
              red_d    = mask_q[0];
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(FLASH_CYCLES);
              state_d  = S_FLASH;
            end
`else
            level_d = LVL_W'(1);
            state_d = S_REQ;
`endif
          end
        end
        S_END: if (enable) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      mask_q     <= '0;
      red_q      <= '0;
      green_q    <= '0;
      score_q    <= '0;
      level_q    <= LVL_W'(1);
      lives_q    <= LIVES_INIT;
      end_game_q <= 1'b0;
      pair_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mask_q     <= mask_d;
      red_q      <= red_d;
      green_q    <= green_d;
      score_q    <= score_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      end_game_q <= end_game_d;
      pair_req_q <= pair_req_d;
    end
  end

  assign red_light         = red_q;
  assign green             = green_q;
  assign score             = score_q;
  assign level             = level_q;
  assign lives             = lives_q;
  assign end_game          = end_game_q;
  assign pair_bus.pair_req = pair_req_q;
endmodule

// File: tb/tb_memory_game_n.sv
// Directed bench for memory_game_n (NUM_PAIRS=3, N_LEDS=16, FLASH=4, GAP=2,
// SCORE_W=2, LIVES=2). Inputs change and outputs are sampled on negedge.
module tb_memory_game_n;
  logic        clk = 1'b0;
  logic        rst, enable, b_in, game_timeout;
  logic [15:0] switch_in;
  logic [15:0] red_light;
  logic [2:0]  green;
  logic [1:0]  score, level, lives;
  logic        end_game;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_lives;
  logic [1:0] exp_score;

`ifdef MEMORY_GAME_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'd2;
`else
  localparam logic [1:0] LIVES_INIT = 2'd0;
`endif

  always #5 clk = ~clk;

  memory_game_n_if #(.NUM_PAIRS(3), .IDX_W(4)) pbus ();

  memory_game_n #(
    .N_LEDS(16), .NUM_PAIRS(3), .IDX_W(4), .FLASH_CYCLES(4),
    .GAP_CYCLES(2), .SCORE_W(2), .LIVES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .b_in(b_in), .switch_in(switch_in),
    .game_timeout(game_timeout), .pair_bus(pbus), .red_light(red_light),
    .green(green), .score(score), .level(level), .lives(lives), .end_game(end_game)
  );

  typedef struct {
    logic        b;
    logic [15:0] sw;
    logic        pv;
    logic [23:0] pidx;
    logic [15:0] red;
    logic [2:0]  grn;
    logic [1:0]  sc;
    logic [1:0]  lvl;
    logic        pr;
  } vec_t;
  vec_t tbl [24];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] red, input logic [2:0] g,
                         input logic [1:0] s, input logic [1:0] l, input logic pr,
                         input logic eg);
    chk({name, " red"},   32'(red_light),     32'(red));
    chk({name, " green"}, 32'(green),         32'(g));
    chk({name, " score"}, 32'(score),         32'(s));
    chk({name, " level"}, 32'(level),         32'(l));
    chk({name, " lives"}, 32'(lives),         32'(exp_lives));
    chk({name, " preq"},  32'(pbus.pair_req), 32'(pr));
    chk({name, " endg"},  32'(end_game),      32'(eg));
  endtask

  task automatic setrow(input int i, input logic b, input logic [15:0] sw, input logic pv,
                        input logic [23:0] pidx, input logic [15:0] red, input logic [2:0] g,
                        input logic [1:0] s, input logic [1:0] l, input logic pr);
    tbl[i] = '{b: b, sw: sw, pv: pv, pidx: pidx, red: red, grn: g, sc: s, lvl: l, pr: pr};
  endtask

  task automatic give_pairs(input logic [23:0] pidx);
    pbus.pair_valid = 1'b1;
    pbus.pair_idx   = pidx;
    cyc();
    pbus.pair_valid = 1'b0;
  endtask

  task automatic enter(input logic [15:0] sw);
    switch_in = sw;
    b_in      = 1'b1;
    cyc();
    b_in      = 1'b0;
  endtask

  // Called on the first lit sample; ends on the first dark sample in ENTER.
  task automatic flash_seq(input string name, input logic [15:0] m0, input logic [15:0] m1,
                           input logic [15:0] m2, input int unsigned n);
    logic [15:0] m;
    for (int unsigned k = 0; k < n; k++) begin
      m = (k == 0) ? m0 : (k == 1) ? m1 : m2;
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s lit k%0d c%0d", name, k, c), 32'(red_light), 32'(m));
        cyc();
      end
      if (k + 1 < n) begin
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("%s gap k%0d c%0d", name, k, c), 32'(red_light), 32'h0);
          cyc();
        end
      end
    end
    chk({name, " enter dark"}, 32'(red_light), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; b_in = 1'b0; game_timeout = 1'b0; switch_in = '0;
    pbus.pair_valid = 1'b0; pbus.pair_idx = '0;
    exp_lives = LIVES_INIT;
    exp_score = '0;

    // Game 1, level 1 win then level 2 win, cycle by cycle.
    setrow(0,  1, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd0, 2'd1, 0);
    setrow(1,  0, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd0, 2'd1, 1);
    setrow(2,  0, 16'h0,    1, 24'h39,    16'h0208, 3'b000, 2'd0, 2'd1, 0);
    for (int i = 3; i <= 5; i++) setrow(i, 0, 16'h0, 0, 24'h0, 16'h0208, 3'b000, 2'd0, 2'd1, 0);
    setrow(6,  0, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd0, 2'd1, 0);
    setrow(7,  1, 16'h0208, 0, 24'h0,     16'h0,    3'b001, 2'd1, 2'd2, 0);
    setrow(8,  0, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd1, 2'd2, 1);
    setrow(9,  0, 16'h0,    1, 24'h7C55,  16'h0020, 3'b000, 2'd1, 2'd2, 0);
    for (int i = 10; i <= 12; i++) setrow(i, 0, 16'h0, 0, 24'h0, 16'h0020, 3'b000, 2'd1, 2'd2, 0);
    for (int i = 13; i <= 14; i++) setrow(i, 0, 16'h0, 0, 24'h0, 16'h0,    3'b000, 2'd1, 2'd2, 0);
    for (int i = 15; i <= 18; i++) setrow(i, 0, 16'h0, 0, 24'h0, 16'h1080, 3'b000, 2'd1, 2'd2, 0);
    setrow(19, 0, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd1, 2'd2, 0);
    setrow(20, 1, 16'h0020, 0, 24'h0,     16'h0,    3'b001, 2'd1, 2'd2, 0);
    setrow(21, 0, 16'h0020, 0, 24'h0,     16'h0,    3'b001, 2'd1, 2'd2, 0);
    setrow(22, 1, 16'h1080, 0, 24'h0,     16'h0,    3'b011, 2'd2, 2'd3, 0);
    setrow(23, 0, 16'h0,    0, 24'h0,     16'h0,    3'b000, 2'd2, 2'd3, 1);

    cyc(); cyc();
    chk_all("reset", 16'h0, 3'b000, 2'd0, 2'd1, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      b_in = tbl[i].b; switch_in = tbl[i].sw;
      pbus.pair_valid = tbl[i].pv; pbus.pair_idx = tbl[i].pidx;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].red, tbl[i].grn, tbl[i].sc, tbl[i].lvl,
              tbl[i].pr, 1'b0);
    end
    b_in = 1'b0; pbus.pair_valid = 1'b0;

    // Level 3 flash order and win (score 2 -> 3).
    give_pairs(24'hF42201);
    flash_seq("l3", 16'h0003, 16'h0004, 16'h8010, 3);
    enter(16'h0003); chk_all("l3 e0", 16'h0, 3'b001, 2'd2, 2'd3, 1'b0, 1'b0);
    enter(16'h0004); chk_all("l3 e1", 16'h0, 3'b011, 2'd2, 2'd3, 1'b0, 1'b0);
    enter(16'h8010); chk_all("l3 e2", 16'h0, 3'b111, 2'd3, 2'd3, 1'b0, 1'b0);
    cyc();           chk_all("l3 req", 16'h0, 3'b000, 2'd3, 2'd3, 1'b1, 1'b0);

    // Fourth win: score saturates, level capped.
    give_pairs(24'hF42201);
    flash_seq("sat", 16'h0003, 16'h0004, 16'h8010, 3);
    enter(16'h0003); enter(16'h0004); enter(16'h8010);
    chk_all("sat win", 16'h0, 3'b111, 2'd3, 2'd3, 1'b0, 1'b0);
    cyc(); chk_all("sat req", 16'h0, 3'b000, 2'd3, 2'd3, 1'b1, 1'b0);

    // Timeout while waiting for pairs; pair_valid in END/IDLE ignored.
    game_timeout = 1'b1;
    cyc(); chk_all("to wait", 16'h0, 3'b000, 2'd3, 2'd3, 1'b0, 1'b1);
    game_timeout = 1'b0;
    pbus.pair_valid = 1'b1; pbus.pair_idx = 24'hF42201;
    cyc(); chk_all("idle hold", 16'h0, 3'b000, 2'd3, 2'd3, 1'b0, 1'b1);
    cyc(); pbus.pair_valid = 1'b0;
    chk_all("idle pv", 16'h0, 3'b000, 2'd3, 2'd3, 1'b0, 1'b1);

    // Game 2: level 1 win, then wrong entry on pair 1 at level 2.
    b_in = 1'b1; cyc(); b_in = 1'b0;
    chk_all("g2 start", 16'h0, 3'b000, 2'd0, 2'd1, 1'b0, 1'b0);
    cyc(); chk_all("g2 req", 16'h0, 3'b000, 2'd0, 2'd1, 1'b1, 1'b0);
    give_pairs(24'h000039);
    flash_seq("g2l1", 16'h0208, 16'h0, 16'h0, 1);
    enter(16'h0208); chk_all("g2l1 win", 16'h0, 3'b001, 2'd1, 2'd2, 1'b0, 1'b0);
    cyc();           chk_all("g2l1 req", 16'h0, 3'b000, 2'd1, 2'd2, 1'b1, 1'b0);
    give_pairs(24'h007C55);
    flash_seq("g2l2", 16'h0020, 16'h1080, 16'h0, 2);
    enter(16'h0020); chk_all("g2l2 e0", 16'h0, 3'b001, 2'd1, 2'd2, 1'b0, 1'b0);
    enter(16'h1000);
`ifdef MEMORY_GAME_LIVES_EN
    exp_lives = 2'd1;
    chk_all("miss1", 16'h0020, 3'b000, 2'd1, 2'd2, 1'b0, 1'b0);
    flash_seq("replay", 16'h0020, 16'h1080, 16'h0, 2);
    enter(16'h0021);
    exp_lives = 2'd0;
    chk_all("miss2", 16'h0, 3'b000, 2'd1, 2'd2, 1'b0, 1'b1);
    cyc(); chk_all("miss2 idle", 16'h0, 3'b000, 2'd1, 2'd2, 1'b0, 1'b1);
    b_in = 1'b1; cyc(); b_in = 1'b0;
    exp_lives = LIVES_INIT;
    chk_all("g3 start", 16'h0, 3'b000, 2'd0, 2'd1, 1'b0, 1'b0);
    cyc(); chk_all("g3 req", 16'h0, 3'b000, 2'd0, 2'd1, 1'b1, 1'b0);
    exp_score = 2'd0;
`else
    chk_all("miss", 16'h0, 3'b000, 2'd1, 2'd1, 1'b0, 1'b0);
    cyc(); chk_all("miss req", 16'h0, 3'b000, 2'd1, 2'd1, 1'b1, 1'b0);
    exp_score = 2'd1;
`endif

    // Timeout coincident with a correct final entry: END wins.
    give_pairs(24'h000039);
    flash_seq("to", 16'h0208, 16'h0, 16'h0, 1);
    switch_in = 16'h0208; b_in = 1'b1; game_timeout = 1'b1;
    cyc(); b_in = 1'b0; game_timeout = 1'b0;
    chk_all("to win", 16'h0, 3'b000, exp_score, 2'd1, 1'b0, 1'b1);
    cyc();
    chk_all("to idle", 16'h0, 3'b000, exp_score, 2'd1, 1'b0, 1'b1);

    // Reset mid-FLASH.
    b_in = 1'b1; cyc(); b_in = 1'b0; cyc();
    give_pairs(24'h000039);
    chk("rst pre lit", 32'(red_light), 32'h0208);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    exp_lives = LIVES_INIT;
    chk_all("rst", 16'h0, 3'b000, 2'd0, 2'd1, 1'b0, 1'b0);
    cyc(); chk("rst stays dark", 32'(red_light), 32'h0);

    // enable low for 10 cycles mid-FLASH stretches the flash.
    b_in = 1'b1; cyc(); b_in = 1'b0; cyc();
    give_pairs(24'h000039);
    chk("en lit c0", 32'(red_light), 32'h0208);
    cyc(); chk("en lit c1", 32'(red_light), 32'h0208);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(); chk($sformatf("en hold %0d", i), 32'(red_light), 32'h0208);
    end
    enable = 1'b1;
    cyc(); chk("en lit c2", 32'(red_light), 32'h0208);
    cyc(); chk("en lit c3", 32'(red_light), 32'h0208);
    cyc(); chk("en dark", 32'(red_light), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
